// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel-arbitration slice.
package dma_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_REQ = 2'd1,
        ACTIVE   = 2'd2,
        RELEASE  = 2'd3
    } arbState_t;

    typedef struct packed {
        logic dreqSenseLow;
        logic dackSenseHigh;
        logic rotatingPriority;
        logic controllerDisable;
    } commandBits_t;

    // Effective request vector: polarity-corrected, masked hardware requests
    // plus unmaskable software requests; nothing while the controller is disabled.
    function automatic logic [NUM_CH-1:0] eff_req(
        input commandBits_t      cmd,
        input logic [NUM_CH-1:0] dreq,
        input logic [NUM_CH-1:0] mask,
        input logic [NUM_CH-1:0] sw_req
    );
        logic [NUM_CH-1:0] hw;
        hw = (dreq ^ {NUM_CH{cmd.dreqSenseLow}}) & ~mask;
        return cmd.controllerDisable ? '0 : (hw | sw_req);
    endfunction

    // One-hot vector for a channel index.
    function automatic logic [NUM_CH-1:0] chan_onehot(input logic [CH_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Rotate-and-pick priority encoder: the first set request at or above ptr
// (wrapping modulo the channel count) wins.
module dma_priority_encoder
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              any,
    output logic [CH_W-1:0]   idx
);

    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [CH_W-1:0]     offset;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: NUM_CH];

    // Lowest set bit of the rotated vector, mapped back to an absolute channel.
    always_comb begin
        any    = |req;
        offset = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = i[CH_W-1:0];
            end
        end
        idx = ptr + offset;
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// Channel arbitration ahead of timingAndControl: forms effective requests,
// runs the HRQ/HLDA hold handshake, grants one channel and drives DACK.
module dma_priority_arbiter
    import dma_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              dreqSenseLow,
    input  logic              dackSenseHigh,
    input  logic              rotatingPriority,
    input  logic              controllerDisable,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] requestReg,
    input  logic              HLDA,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [CH_W-1:0]   grantChannel,
    output logic [CH_W-1:0]   priorityPtr
);

    commandBits_t      cmd;
    logic [NUM_CH-1:0] effReq;
    logic [CH_W-1:0]   scanPtr;
    logic              reqAny;
    logic [CH_W-1:0]   winner;
    arbState_t         state;
    logic [NUM_CH-1:0] dackInt;

    assign cmd = '{dreqSenseLow:      dreqSenseLow,
                   dackSenseHigh:     dackSenseHigh,
                   rotatingPriority:  rotatingPriority,
                   controllerDisable: controllerDisable};

    assign effReq = eff_req(cmd, DREQ, maskReg, requestReg);

    // Fixed mode always scans from channel 0, even before the pointer register clears.
    assign scanPtr = cmd.rotatingPriority ? priorityPtr : '0;

    dma_priority_encoder u_encoder (
        .req (effReq),
        .ptr (scanPtr),
        .any (reqAny),
        .idx (winner)
    );

    // DACK polarity is applied outside the state so a command change takes effect at once.
    assign DACK = dackInt ^ {NUM_CH{~cmd.dackSenseHigh}};

    // Hold-handshake FSM with registered HRQ, grant, DACK and priority pointer.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            HRQ          <= 1'b0;
            grantValid   <= 1'b0;
            grantChannel <= '0;
            priorityPtr  <= '0;
            dackInt      <= '0;
        end else begin
            if (!cmd.rotatingPriority) begin
                priorityPtr <= '0;
            end
            case (state)
                IDLE: begin
                    if (reqAny) begin
                        state <= HOLD_REQ;
                        HRQ   <= 1'b1;
                    end
                end
                HOLD_REQ: begin
                    // A request that vanishes before the CPU answers abandons the hold.
                    if (!reqAny) begin
                        state <= RELEASE;
                        HRQ   <= 1'b0;
                    end else if (HLDA) begin
                        state        <= ACTIVE;
                        grantChannel <= winner;
                        grantValid   <= 1'b1;
                        dackInt      <= chan_onehot(winner);
                    end
                end
                ACTIVE: begin
                    // serviceDone wins over a simultaneous HLDA drop, so rotation still happens.
                    if (serviceDone) begin
                        state      <= RELEASE;
                        HRQ        <= 1'b0;
                        grantValid <= 1'b0;
                        dackInt    <= '0;
                        if (cmd.rotatingPriority) begin
                            priorityPtr <= grantChannel + CH_W'(1);
                        end
                    end else if (!HLDA) begin
                        state      <= RELEASE;
                        HRQ        <= 1'b0;
                        grantValid <= 1'b0;
                        dackInt    <= '0;
                    end
                end
                RELEASE: begin
                    if (!HLDA) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
